// File: rtl/slot_gpio_bank.sv
// slot_gpio_bank: per-slot GPIO/IRQ register bank; bus_* register port in, bus_rdata/bus_rvalid out, pad_i in, pad_o/pad_oe/irq out
module slot_gpio_bank #(
  parameter int SLOTS       = 2,
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      bus_addr,
  input  logic [DATA_W-1:0]      bus_wdata,
  input  logic                   bus_we,
  input  logic                   bus_re,
  output logic [DATA_W-1:0]      bus_rdata,
  output logic                   bus_rvalid,
  input  logic [SLOTS*WIDTH-1:0] pad_i,
  output logic [SLOTS*WIDTH-1:0] pad_o,
  output logic [SLOTS*WIDTH-1:0] pad_oe,
  output logic                   irq
);
  localparam int N  = SLOTS * WIDTH;
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  localparam int AW = $clog2(SYNC_STAGES + 2);
  logic [N-1:0] out_q, dir_q, mask_q, rise_q, fall_q, status_q, p_q;
  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] s, set, clr, wsel, wbits, rd_sel;
  logic [AW-1:0] arm_q;
  logic armed, in_range, wr, unused_ok;
  logic [2:0] kind;
  logic [SW-1:0] slot;
  logic [WIDTH-1:0] rd_bits;
  int sh;
  assign unused_ok = ^bus_wdata;
  assign in_range = int'(bus_addr) < SLOTS * 8;
  assign kind = 3'(int'(bus_addr) / SLOTS);
  assign slot = SW'(int'(bus_addr) % SLOTS);
  assign sh = int'(slot) * WIDTH;
  assign wr = bus_we & in_range;
  assign wsel = N'({WIDTH{1'b1}}) << sh;
  assign wbits = N'(bus_wdata[WIDTH-1:0]) << sh;
  assign s = sync_q[SYNC_STAGES-1];
  assign armed = arm_q == AW'(SYNC_STAGES + 1);
  assign set = armed ? ((s & ~p_q & rise_q) | (~s & p_q & fall_q)) : '0;
  assign clr = (wr && kind == 3'd5) ? wbits : '0;
  assign pad_o = out_q;
  assign pad_oe = dir_q;
  assign rd_sel = kind == 3'd0 ? out_q :
                  kind == 3'd1 ? s :
                  kind == 3'd2 ? dir_q :
                  kind == 3'd3 ? status_q :
                  kind == 3'd4 ? mask_q :
                  kind == 3'd6 ? rise_q :
                  kind == 3'd7 ? fall_q : '0;
  assign rd_bits = in_range ? WIDTH'(rd_sel >> sh) : '0;
  function automatic logic [N-1:0] upd(input logic [N-1:0] q, input logic [2:0] k);
    return (wr && kind == k) ? ((q & ~wsel) | wbits) : q;
  endfunction
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      out_q <= '0;
      dir_q <= '0;
      mask_q <= '0;
      rise_q <= '1;
      fall_q <= '0;
      status_q <= '0;
      p_q <= '0;
      arm_q <= '0;
      irq <= 1'b0;
      bus_rdata <= '0;
      bus_rvalid <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q <= upd(out_q, 3'd0);
      dir_q <= upd(dir_q, 3'd2);
      mask_q <= upd(mask_q, 3'd4);
      rise_q <= upd(rise_q, 3'd6);
      fall_q <= upd(fall_q, 3'd7);
      status_q <= (status_q & ~clr) | set;
      p_q <= s;
      arm_q <= armed ? arm_q : arm_q + 1'b1;
      irq <= |(status_q & mask_q);
      bus_rvalid <= bus_re;
      if (bus_re) bus_rdata <= DATA_W'(rd_bits);
      sync_q[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
endmodule

// File: doc/slot_gpio_bank.md
# slot_gpio_bank

Parametrised per-slot GPIO and interrupt register bank behind the board's SPI-slave register bus. It generalises the fixed slot register map (output, input, direction, interrupt status, mask, clear) to SLOTS slots of WIDTH bits. It adds per-bit rising/falling edge selection, input synchronisation and a post-reset arming window. A single `irq` line goes to the STM.

## Interface
- `SLOTS`, 2: number of slots; register address = slot + SLOTS*kind.
- `WIDTH`, 8: I/O bits per slot, 1..DATA_W.
- `ADDR_W`, 7: register bus address width; must cover SLOTS*8 addresses.
- `DATA_W`, 16: register bus data width.
- `SYNC_STAGES`, 2: input synchroniser depth, >= 2.
- `sys_clk` in 1: system clock; everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bus_addr` in ADDR_W: register address.
- `bus_wdata` in DATA_W: write data.
- `bus_we` in 1: write strobe, one cycle per access.
- `bus_re` in 1: read strobe, one cycle per access.
- `bus_rdata` out DATA_W: read data.
- `bus_rvalid` out 1: one-cycle pulse marking `bus_rdata` valid.
- `pad_i` in SLOTS*WIDTH: pad input values; slot s occupies bits [s*WIDTH +: WIDTH].
- `pad_o` out SLOTS*WIDTH: pad output values.
- `pad_oe` out SLOTS*WIDTH: pad output enables, 1 = drive.
- `irq` out 1: OR of all pending unmasked interrupts, registered.

## Operation
- Register kinds, at address slot + SLOTS*k:
  - k=0 OUT: R/W output value.
  - k=1 IN: read-only synchronised pad value.
  - k=2 DIR: R/W, 1 = output.
  - k=3 STATUS: read-only latched edge events.
  - k=4 MASK: R/W, 1 = enabled.
  - k=5 CLEAR: write-1-to-clear STATUS, reads 0.
  - k=6 RISE: R/W, 1 = rising edge sets status.
  - k=7 FALL: R/W, 1 = falling edge sets status.
- Only bits [WIDTH-1:0] of each register are implemented. Upper write bits are ignored; upper read bits are 0.
- Out-of-range addresses (slot >= SLOTS or kind > 7): writes ignored; reads return 0 with `bus_rvalid` still pulsed.
- Writes to IN or STATUS are ignored.
- `bus_we` and `bus_re` in the same cycle: the write is performed, and the read returns the pre-write contents.
- `pad_o` = OUT; `pad_oe` = DIR.
- IN always reflects the synchronised pad, regardless of DIR. Output pins therefore loop back and can raise interrupts.
- Edge detect per bit compares the synchronised value `s` with its one-cycle-delayed copy `p`:
  - rising = s & ~p & RISE
  - falling = ~s & p & FALL
- STATUS bit update each cycle:
  - Set on (rising | falling).
  - Cleared by a CLEAR write with that bit at 1.
  - If set and clear occur in the same cycle, set wins.
- STATUS latches regardless of MASK. MASK gates only `irq`.
- `irq` <= |(STATUS & MASK) over all slots, registered.
- Arming counter: after `rst` deasserts, edge detection is suppressed for SYNC_STAGES+1 cycles. This prevents a spurious rising event from pads that are already high.
- Reset values: OUT=0, DIR=0 (all inputs), STATUS=0, MASK=0, RISE=all ones, FALL=0, synchroniser and delay stages=0, `irq`=0, `bus_rdata`=0, `bus_rvalid`=0, arming counter restarted.
- Reset asserted mid-operation forces all of the above on the next edge. A read in progress at that edge produces no `bus_rvalid`.

## Timing
- Write: the register updates on the `sys_clk` edge that samples `bus_we`. `pad_o`/`pad_oe` change in that same cycle.
- Read: `bus_rdata`/`bus_rvalid` are registered and appear 1 cycle after `bus_re`. `bus_rdata` holds its value until the next read.
- Pad-to-IN latency is SYNC_STAGES cycles.
- Pad-to-STATUS latency is SYNC_STAGES+1 cycles; pad-to-`irq` is SYNC_STAGES+2 cycles.
- After a CLEAR write (with no new event), `irq` falls 1 cycle after STATUS clears, i.e. 2 cycles after the `bus_we` cycle.
- A MASK write changes `irq` 1 cycle after the register update.
- Back-to-back accesses are allowed every cycle.

## Test plan
- Reset then read all 16 addresses (SLOTS=2) -> RISE reads 0x00FF; all other registers read 0x0000; `irq`=0.
- Write OUT slot1=0xA5 and DIR slot1=0xFF -> `pad_o[15:8]`=0xA5 and `pad_oe[15:8]`=0xFF; a read of addr 3 (IN slot1) 2+ cycles later returns 0xA5.
- Set MASK slot0=0x01, then take `pad_i[0]` 0->1 -> STATUS slot0=0x01 and `irq`=1 exactly 4 cycles after the pad change. Write CLEAR=0x01 -> STATUS=0 and `irq`=0 two cycles later.
- RISE slot0=0, FALL slot0=0x02, MASK=0x02: a rising edge on `pad_i[1]` gives no status; a falling edge gives STATUS=0x02 and `irq`=1.
- Hold `pad_i`=all ones through reset release -> STATUS stays 0 for 50 cycles.
- Arrange a CLEAR write in the same cycle a new edge is detected on that bit -> the STATUS bit remains 1.
- Out-of-range read at addr 0x7F -> `bus_rvalid` pulses with data 0x0000. A write to 0x7F changes no register.
